ir_cash_arbiter: RTL and testbench

//  Shares the single instruction-cache (cash) read port between two requesters:
//  the IR regfile loader (init fill / load bursts) and the decoder fetch (P0/P1/P2

---
 rtl/ir_cash_arbiter_if.sv | 34 +++
 rtl/ir_cash_arbiter.sv | 111 +++++++++++
 tb/tb_ir_cash_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ir_cash_arbiter_if.sv
// Request/response bundle between the two cache requesters, the arbiter and the
// instruction cache read port.
interface ir_cash_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 8
);
   logic                  ld_req;
   logic [ADDR_WIDTH-1:0] ld_addr;
   logic                  ld_gnt;
   logic                  ld_rvalid;
   logic [DATA_WIDTH-1:0] ld_rdata;
   logic                  fe_req;
   logic [ADDR_WIDTH-1:0] fe_addr;
   logic                  fe_gnt;
   logic                  fe_rvalid;
   logic [DATA_WIDTH-1:0] fe_rdata;
   logic                  cash_ren;
   logic [ADDR_WIDTH-1:0] cash_addr;
   logic [DATA_WIDTH-1:0] cash_rdata;

   // Arbiter side
   modport slave (
      input  ld_req, ld_addr, fe_req, fe_addr, cash_rdata,
      output ld_gnt, ld_rvalid, ld_rdata, fe_gnt, fe_rvalid, fe_rdata,
             cash_ren, cash_addr
   );

   // Requester / cache side
   modport master (
      output ld_req, ld_addr, fe_req, fe_addr, cash_rdata,
      input  ld_gnt, ld_rvalid, ld_rdata, fe_gnt, fe_rvalid, fe_rdata,
             cash_ren, cash_addr
   );
endinterface

// File: rtl/ir_cash_arbiter.sv
// Shares the instruction-cache read port between the IR loader and the decoder
// fetch. One read in flight at a time; loader has priority, bounded by a burst
// counter so a pending fetch is served after MAX_BURST consecutive loader reads.
module ir_cash_arbiter #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic            clk,
   input  logic            rst,
   ir_cash_arbiter_if.slave bus,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);
   localparam logic [1:0] LAT_INIT  = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

   state_t                state;
   logic                  owner_fe;
   logic [3:0]            burst_cnt;
   logic [1:0]            lat_cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  ren_q;
   logic                  ld_gnt_q;
   logic                  fe_gnt_q;
   logic                  ld_rv_q;
   logic                  fe_rv_q;
   logic                  any_req;
   logic                  pick_fe;
   logic [DATA_WIDTH-1:0] rdata;

   // Arbitration decision: fetch wins when alone or when the loader burst is used up
   always_comb begin
      any_req = bus.ld_req | bus.fe_req;
      pick_fe = bus.fe_req & (~bus.ld_req | (burst_cnt == BURST_LIM));
   end

   // Transaction FSM with registered grant/enable/valid pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         owner_fe  <= 1'b0;
         burst_cnt <= '0;
         lat_cnt   <= '0;
         addr_q    <= '0;
         ren_q     <= 1'b0;
         ld_gnt_q  <= 1'b0;
         fe_gnt_q  <= 1'b0;
         ld_rv_q   <= 1'b0;
         fe_rv_q   <= 1'b0;
      end else begin
         ren_q    <= 1'b0;
         ld_gnt_q <= 1'b0;
         fe_gnt_q <= 1'b0;
         ld_rv_q  <= 1'b0;
         fe_rv_q  <= 1'b0;
         case (state)
            IDLE, RESP: begin
               // A loader win with fetch waiting is the only case that extends the burst
               if (!bus.fe_req || pick_fe) burst_cnt <= '0;
               else                        burst_cnt <= burst_cnt + 4'd1;
               if (any_req) begin
                  state    <= ISSUE;
                  owner_fe <= pick_fe;
                  addr_q   <= pick_fe ? bus.fe_addr : bus.ld_addr;
                  ren_q    <= 1'b1;
                  ld_gnt_q <= ~pick_fe;
                  fe_gnt_q <= pick_fe;
               end else begin
                  state <= IDLE;
               end
            end
            ISSUE: begin
               if (RD_LAT == 1) begin
                  state   <= RESP;
                  ld_rv_q <= ~owner_fe;
                  fe_rv_q <= owner_fe;
               end else begin
                  state   <= WAIT;
                  lat_cnt <= LAT_INIT;
               end
            end
            WAIT: begin
               if (lat_cnt == '0) begin
                  state   <= RESP;
                  ld_rv_q <= ~owner_fe;
                  fe_rv_q <= owner_fe;
               end else begin
                  lat_cnt <= lat_cnt - 2'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rdata         = bus.cash_rdata;
   assign bus.cash_ren  = ren_q;
   assign bus.cash_addr = addr_q;
   assign bus.ld_gnt    = ld_gnt_q;
   assign bus.fe_gnt    = fe_gnt_q;
   assign bus.ld_rvalid = ld_rv_q;
   assign bus.fe_rvalid = fe_rv_q;
   assign bus.ld_rdata  = ld_rv_q ? rdata : '0;
   assign bus.fe_rdata  = fe_rv_q ? rdata : '0;
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_ir_cash_arbiter.sv
// Bench for ir_cash_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3,
// each with a behavioural cache returning a ^ 8'hB7 after the read latency.
module tb_ir_cash_arbiter;

   logic clk = 1'b0;
   logic rst1, rst3;
   logic busy1, busy3;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ir_cash_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus1 ();
   ir_cash_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus3 ();

   ir_cash_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RD_LAT(1), .MAX_BURST(4)) dut1 (
      .clk(clk), .rst(rst1), .bus(bus1.slave), .busy(busy1));
   ir_cash_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RD_LAT(3), .MAX_BURST(4)) dut3 (
      .clk(clk), .rst(rst3), .bus(bus3.slave), .busy(busy3));

   function automatic logic [7:0] mem(input logic [7:0] a);
      return a ^ 8'hB7;
   endfunction

   // Cache models: data only valid RD_LAT cycles after cash_ren, garbage otherwise
   logic       c1_v = 1'b0;
   logic [7:0] c1_d = 8'h00;
   logic       c3_v [3] = '{1'b0, 1'b0, 1'b0};
   logic [7:0] c3_d [3] = '{8'h00, 8'h00, 8'h00};
   always @(posedge clk) begin
      c1_v <= bus1.cash_ren;
      c1_d <= mem(bus1.cash_addr);
      c3_v[0] <= bus3.cash_ren;
      c3_d[0] <= mem(bus3.cash_addr);
      for (int i = 1; i < 3; i++) begin
         c3_v[i] <= c3_v[i-1];
         c3_d[i] <= c3_d[i-1];
      end
   end
   assign bus1.cash_rdata = c1_v ? c1_d : 8'hEE;
   assign bus3.cash_rdata = c3_v[2] ? c3_d[2] : 8'hEE;

   // {ld_gnt, fe_gnt, ld_rvalid, fe_rvalid, cash_ren, busy, ld_rdata, fe_rdata, cash_addr}
   function automatic logic [29:0] pack1();
      return {bus1.ld_gnt, bus1.fe_gnt, bus1.ld_rvalid, bus1.fe_rvalid, bus1.cash_ren, busy1,
              bus1.ld_rdata, bus1.fe_rdata, bus1.cash_addr};
   endfunction
   function automatic logic [29:0] pack3();
      return {bus3.ld_gnt, bus3.fe_gnt, bus3.ld_rvalid, bus3.fe_rvalid, bus3.cash_ren, busy3,
              bus3.ld_rdata, bus3.fe_rdata, bus3.cash_addr};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        ld_req;
      logic [7:0]  ld_addr;
      logic        fe_req;
      logic [7:0]  fe_addr;
      logic [29:0] exp;
   } vec_t;
   vec_t vec [16];

   // dut3 event log (cycle stamps) and dut1 scoreboard
   bit         mon3 = 1'b0;
   int         ren_q [$];
   int         rv_q [$];
   logic [7:0] rvd_q [$];
   bit         sb_on = 1'b0;
   logic [7:0] ld_exp [$];
   logic [7:0] fe_exp [$];
   int         ld_gnts = 0, fe_gnts = 0, ld_rvs = 0, fe_rvs = 0;

   // Record dut3 issue and loader-return cycles
   always @(negedge clk) begin
      if (mon3) begin
         if (bus3.cash_ren) ren_q.push_back(cyc);
         if (bus3.ld_rvalid) begin
            rv_q.push_back(cyc);
            rvd_q.push_back(bus3.ld_rdata);
         end
      end
   end

   // Score dut1 returns against the addresses the requesters had granted
   always @(negedge clk) begin
      if (sb_on) begin
         if (bus1.ld_gnt) ld_gnts++;
         if (bus1.fe_gnt) fe_gnts++;
         if (bus1.ld_rvalid) begin
            ld_rvs++;
            if (ld_exp.size() == 0) begin
               checks++; errors++;
               $display("FAIL ld_rvalid_unexpected: got data 0x%0h expected no rvalid", bus1.ld_rdata);
            end else check("fill_ld_data", bus1.ld_rdata, ld_exp.pop_front());
         end
         if (bus1.fe_rvalid) begin
            fe_rvs++;
            if (fe_exp.size() == 0) begin
               checks++; errors++;
               $display("FAIL fe_rvalid_unexpected: got data 0x%0h expected no rvalid", bus1.fe_rdata);
            end else check("fill_fe_data", bus1.fe_rdata, fe_exp.pop_front());
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] ord;
      logic [9:0] exp_ord;
      int         n;
      bit         got;
      bit         ld_done;
      int         fe_issued;

      //           ld  ld_addr fe  fe_addr  {gnt_l,gnt_f,rv_l,rv_f,ren,busy} ld_rd fe_rd cash_addr
      vec[0]  = '{1'b0, 8'h00, 1'b1, 8'h12, {6'b000000, 8'h00, 8'h00, 8'h00}};
      vec[1]  = '{1'b0, 8'h00, 1'b1, 8'h12, {6'b010011, 8'h00, 8'h00, 8'h12}};
      vec[2]  = '{1'b0, 8'h00, 1'b0, 8'h12, {6'b000101, 8'h00, 8'hA5, 8'h12}};
      vec[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, {6'b000000, 8'h00, 8'h00, 8'h12}};
      vec[4]  = '{1'b1, 8'h00, 1'b1, 8'h40, {6'b000000, 8'h00, 8'h00, 8'h12}};
      vec[5]  = '{1'b1, 8'h00, 1'b1, 8'h40, {6'b100011, 8'h00, 8'h00, 8'h00}};
      vec[6]  = '{1'b0, 8'h00, 1'b1, 8'h40, {6'b001001, 8'hB7, 8'h00, 8'h00}};
      vec[7]  = '{1'b0, 8'h00, 1'b1, 8'h40, {6'b010011, 8'h00, 8'h00, 8'h40}};
      vec[8]  = '{1'b0, 8'h00, 1'b0, 8'h40, {6'b000101, 8'h00, 8'hF7, 8'h40}};
      vec[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, {6'b000000, 8'h00, 8'h00, 8'h40}};
      vec[10] = '{1'b1, 8'h01, 1'b0, 8'h00, {6'b000000, 8'h00, 8'h00, 8'h40}};
      vec[11] = '{1'b1, 8'h01, 1'b0, 8'h00, {6'b100011, 8'h00, 8'h00, 8'h01}};
      vec[12] = '{1'b1, 8'h02, 1'b0, 8'h00, {6'b001001, 8'hB6, 8'h00, 8'h01}};
      vec[13] = '{1'b1, 8'h02, 1'b0, 8'h00, {6'b100011, 8'h00, 8'h00, 8'h02}};
      vec[14] = '{1'b0, 8'h02, 1'b0, 8'h00, {6'b001001, 8'hB5, 8'h00, 8'h02}};
      vec[15] = '{1'b0, 8'h00, 1'b0, 8'h00, {6'b000000, 8'h00, 8'h00, 8'h02}};

      rst1 = 1'b1; rst3 = 1'b1;
      bus1.ld_req = 1'b0; bus1.ld_addr = 8'h00; bus1.fe_req = 1'b0; bus1.fe_addr = 8'h00;
      bus3.ld_req = 1'b0; bus3.ld_addr = 8'h00; bus3.fe_req = 1'b0; bus3.fe_addr = 8'h00;
      repeat (2) @(negedge clk);
      check("reset_dut1", pack1(), 30'h0);
      check("reset_dut3", pack3(), 30'h0);
      rst1 = 1'b0; rst3 = 1'b0;

      // Single fetch, contention, back-to-back loader reads on RD_LAT=1
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check($sformatf("vec[%0d]", i), pack1(), vec[i].exp);
         bus1.ld_req  = vec[i].ld_req;
         bus1.ld_addr = vec[i].ld_addr;
         bus1.fe_req  = vec[i].fe_req;
         bus1.fe_addr = vec[i].fe_addr;
      end

      // Fairness: both requesters held high
      @(negedge clk);
      bus1.ld_addr = 8'h80; bus1.fe_addr = 8'h90;
      bus1.ld_req = 1'b1; bus1.fe_req = 1'b1;
      ord = '0; n = 0;
      exp_ord = 10'b1000010000;
      for (int t = 0; t < 100 && n < 10; t++) begin
         @(negedge clk);
         if (bus1.ld_gnt && n < 10) begin ord[n] = 1'b0; n++; end
         if (bus1.fe_gnt && n < 10) begin ord[n] = 1'b1; n++; end
      end
      bus1.ld_req = 1'b0; bus1.fe_req = 1'b0;
      check("burst_grant_count", n, 10);
      for (int i = 0; i < 10; i++)
         check($sformatf("burst_order[%0d]", i), ord[i], exp_ord[i]);

      // RD_LAT=3 loader stream with stepping address
      mon3 = 1'b1;
      @(negedge clk);
      bus3.ld_addr = 8'h00; bus3.ld_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         got = 1'b0;
         for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (bus3.ld_gnt) got = 1'b1;
         end
         if (!got) check($sformatf("lat3_gnt_timeout[%0d]", k), 0, 1);
         if (k == 3) bus3.ld_req = 1'b0;
         else        bus3.ld_addr = 8'(k + 1);
      end
      repeat (6) @(negedge clk);
      check("lat3_ren_count", ren_q.size(), 4);
      check("lat3_rv_count", rv_q.size(), 4);
      if (ren_q.size() == 4 && rv_q.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("lat3_latency[%0d]", i), rv_q[i] - ren_q[i], 3);
            check($sformatf("lat3_data[%0d]", i), rvd_q[i], mem(8'(i)));
            if (i > 0) check($sformatf("lat3_period[%0d]", i), ren_q[i] - ren_q[i-1], 4);
         end
      end

      // Reset while a read is waiting in WAIT
      mon3 = 1'b0;
      ren_q.delete(); rv_q.delete(); rvd_q.delete();
      @(negedge clk);
      bus3.ld_addr = 8'h33; bus3.ld_req = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         if (bus3.ld_gnt) got = 1'b1;
      end
      if (!got) check("rst_gnt_timeout", 0, 1);
      bus3.ld_req = 1'b0;
      @(negedge clk);
      check("pre_rst_busy_no_rvalid", {busy3, bus3.ld_rvalid}, 2'b10);
      rst3 = 1'b1;
      #1;
      check("rst_outputs_zero_a", pack3(), 30'h0);
      @(negedge clk);
      check("rst_outputs_zero_b", pack3(), 30'h0);
      rst3 = 1'b0;
      mon3 = 1'b1;
      repeat (8) @(negedge clk);
      check("no_rvalid_after_rst", rv_q.size(), 0);
      check("no_ren_after_rst", ren_q.size(), 0);
      bus3.ld_addr = 8'h44; bus3.ld_req = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         if (bus3.ld_gnt) got = 1'b1;
      end
      if (!got) check("post_rst_gnt_timeout", 0, 1);
      bus3.ld_req = 1'b0;
      repeat (5) @(negedge clk);
      check("post_rst_rv_count", rv_q.size(), 1);
      if (rv_q.size() == 1 && ren_q.size() == 1) begin
         check("post_rst_latency", rv_q[0] - ren_q[0], 3);
         check("post_rst_data", rvd_q[0], 8'hF3);
      end
      mon3 = 1'b0;

      // Loader init fill with random fetch interference on RD_LAT=1
      repeat (4) @(negedge clk);
      sb_on = 1'b1;
      ld_done = 1'b0;
      fe_issued = 0;
      fork
         begin
            for (int k = 0; k < 256; k++) begin
               bit lg;
               bus1.ld_addr = 8'(k);
               bus1.ld_req  = 1'b1;
               lg = 1'b0;
               for (int t = 0; t < 40 && !lg; t++) begin
                  @(negedge clk);
                  if (bus1.ld_gnt) lg = 1'b1;
               end
               if (!lg) begin
                  check($sformatf("fill_ld_gnt_timeout[%0d]", k), 0, 1);
                  break;
               end
               ld_exp.push_back(mem(8'(k)));
            end
            bus1.ld_req = 1'b0;
            ld_done = 1'b1;
         end
         begin
            while (!ld_done) begin
               bit fg;
               repeat ($urandom_range(0, 4)) @(negedge clk);
               if (ld_done) break;
               bus1.fe_addr = 8'($urandom);
               bus1.fe_req  = 1'b1;
               fe_issued++;
               fg = 1'b0;
               for (int t = 0; t < 40 && !fg; t++) begin
                  @(negedge clk);
                  if (bus1.fe_gnt) fg = 1'b1;
               end
               if (!fg) begin
                  bus1.fe_req = 1'b0;
                  check("fill_fe_gnt_timeout", 0, 1);
                  break;
               end
               fe_exp.push_back(mem(bus1.fe_addr));
               bus1.fe_req = 1'b0;
            end
         end
      join
      repeat (6) @(negedge clk);
      sb_on = 1'b0;
      check("fill_ld_gnts", ld_gnts, 256);
      check("fill_ld_rvalids", ld_rvs, 256);
      check("fill_fe_gnts", fe_gnts, fe_issued);
      check("fill_fe_rvalids", fe_rvs, fe_gnts);
      check("fill_ld_left", ld_exp.size(), 0);
      check("fill_fe_left", fe_exp.size(), 0);
      check("fill_fe_seen", fe_issued > 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
